// File: rtl/serial_frame_receiver_if.sv
// Bundle of serial input, frame-control and parallel-output signals for serial_frame_receiver.
// The master drives bits and frame gating; the slave (receiver) returns assembled words and status.
interface serial_frame_receiver_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             i_serial_data;
    logic             i_frame_en;
    logic             i_err_clr;
    logic [WIDTH-1:0] o_parallel_data;
    logic             o_data_valid;
    logic             o_frame_err;
    logic [CNT_W-1:0] o_bit_count;
    logic [7:0]       o_frame_count;

    modport master (
        output i_serial_data, i_frame_en, i_err_clr,
        input  o_parallel_data, o_data_valid, o_frame_err, o_bit_count, o_frame_count
    );

    modport slave (
        input  i_serial_data, i_frame_en, i_err_clr,
        output o_parallel_data, o_data_valid, o_frame_err, o_bit_count, o_frame_count
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Deserializes gated serial bits into WIDTH-bit words, publishing each word only once complete.
// Tracks completed frames and flags frames aborted with bits still pending.
module serial_frame_receiver #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                   o_serial_clk,
    input  logic                   i_reset_n,
    serial_frame_receiver_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             abort;

    always_comb begin
        shift_d     = shift_q;
        data_d      = data_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        valid_d     = 1'b0;
        abort       = 1'b0;

        if (bus.i_frame_en) begin
            shift_d = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], bus.i_serial_data}
                                       : {bus.i_serial_data, shift_q[WIDTH-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
                // Publish the word including the bit arriving on this edge.
                data_d      = shift_d;
                bit_cnt_d   = '0;
                valid_d     = 1'b1;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else begin
            bit_cnt_d = '0;
            abort     = (bit_cnt_q != '0);
        end

        // A new abort outranks a simultaneous clear request.
        if (abort) begin
            err_d = 1'b1;
        end else if (bus.i_err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge o_serial_clk) begin
        if (!i_reset_n) begin
            shift_q     <= '0;
            data_q      <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            data_q      <= data_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_parallel_data = data_q;
    assign bus.o_data_valid    = valid_q;
    assign bus.o_frame_err     = err_q;
    assign bus.o_bit_count     = bit_cnt_q;
    assign bus.o_frame_count   = frame_cnt_q;
endmodule
